// File: rtl/wb_regfile_stall_pkg.sv
// Shared pipeline definitions used by the writeback stage: widths, writeback
// source encodings, the debug record carried down the pipe and the trace hook.
package wb_regfile_stall_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int CNT_W  = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] WB_SRC_ALU  = 2'b00;
  localparam logic [1:0] WB_SRC_MEM  = 2'b01;
  localparam logic [1:0] WB_SRC_PC4  = 2'b10;
  localparam logic [1:0] WB_SRC_ZERO = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } Debug_t;

  typedef enum logic [2:0] {
    STAGE_IF  = 3'd0,
    STAGE_ID  = 3'd1,
    STAGE_EX  = 3'd2,
    STAGE_MEM = 3'd3,
    STAGE_WB  = 3'd4
  } LogStage_e;

  typedef enum logic [1:0] {
    EV_COMMIT = 2'd0,
    EV_STALL  = 2'd1,
    EV_FLUSH  = 2'd2
  } LogEvent_e;

  // Trace hook: builds no hardware, only insists the logged record is fully known.
  function automatic void log_msg(input LogStage_e stage, input LogEvent_e ev,
                                  input Debug_t dbg);
    assert (!$isunknown({stage, ev, dbg}));
  endfunction

endpackage

// File: rtl/wb_regfile_stall_if.sv
// Bundle between the MemWB register / ID stage and the writeback stage.
// master = pipeline side, slave = wb_regfile_stall.
interface wb_regfile_stall_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import wb_regfile_stall_pkg::*;

  logic             en_WB;
  logic             valid_in_WB;
  Debug_t           debug_in_WB;
  logic [XLEN-1:0]  PC4_in_WB;
  logic [4:0]       Rd_addr_WB;
  logic [XLEN-1:0]  ALU_in_WB;
  logic [XLEN-1:0]  DMem_data_WB;
  logic [1:0]       MemtoReg_in_WB;
  logic             RegWrite_in_WB;
  logic [4:0]       Rs1_addr_WB;
  logic [4:0]       Rs2_addr_WB;
  logic [XLEN-1:0]  Rs1_data_WB;
  logic [XLEN-1:0]  Rs2_data_WB;
  logic [XLEN-1:0]  wb_data_out_WB;
  logic             wb_we_out_WB;
  logic [CNT_W-1:0] retired_out_WB;
  Debug_t           debug_out_WB;

  modport master (
    output en_WB, valid_in_WB, debug_in_WB, PC4_in_WB, Rd_addr_WB, ALU_in_WB,
           DMem_data_WB, MemtoReg_in_WB, RegWrite_in_WB, Rs1_addr_WB, Rs2_addr_WB,
    input  Rs1_data_WB, Rs2_data_WB, wb_data_out_WB, wb_we_out_WB,
           retired_out_WB, debug_out_WB
  );

  modport slave (
    input  en_WB, valid_in_WB, debug_in_WB, PC4_in_WB, Rd_addr_WB, ALU_in_WB,
           DMem_data_WB, MemtoReg_in_WB, RegWrite_in_WB, Rs1_addr_WB, Rs2_addr_WB,
    output Rs1_data_WB, Rs2_data_WB, wb_data_out_WB, wb_we_out_WB,
           retired_out_WB, debug_out_WB
  );

endinterface

// File: rtl/wb_regfile_stall_regfile_2r1w.sv
// Architectural register array: one write port, two raw (unbypassed) read ports,
// x0 never stored and always read as zero.
module regfile_2r1w
  import wb_regfile_stall_pkg::*;
#(
  parameter int XLEN = wb_regfile_stall_pkg::XLEN,
  parameter int NREG = wb_regfile_stall_pkg::NREG
) (
  input  logic              clk_WB,
  input  logic              rst_WB,
  input  logic              wrEn,
  input  logic [REG_AW-1:0] wrAddr,
  input  logic [XLEN-1:0]   wrData,
  input  logic [REG_AW-1:0] rdAddr1,
  input  logic [REG_AW-1:0] rdAddr2,
  output logic [XLEN-1:0]   rdData1,
  output logic [XLEN-1:0]   rdData2
);

  logic [XLEN-1:0] regs [NREG];

  // NOTE: the array is reset on purpose so every register reads 0 after reset;
  // this makes it flops rather than an inferred RAM.
  always_ff @(posedge clk_WB or posedge rst_WB) begin
    if (rst_WB) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wrEn && (wrAddr != '0)) begin
      // NOTE: non-blocking so every flop samples pre-edge values, whatever the block order.
      regs[wrAddr] <= wrData;
    end
  end

  assign rdData1 = (rdAddr1 == '0) ? '0 : regs[rdAddr1];
  assign rdData2 = (rdAddr2 == '0) ? '0 : regs[rdAddr2];

endmodule

// File: rtl/wb_regfile_stall.sv
// Writeback stage: selects the writeback value, commits it to the register file,
// bypasses it onto the ID read ports, and tracks retired instructions and debug.
module wb_regfile_stall
  import wb_regfile_stall_pkg::*;
#(
  parameter int XLEN  = wb_regfile_stall_pkg::XLEN,
  parameter int NREG  = wb_regfile_stall_pkg::NREG,
  parameter int CNT_W = wb_regfile_stall_pkg::CNT_W
) (
  input  logic                clk_WB,
  input  logic                rst_WB,
  wb_regfile_stall_if.slave   wb
);

  logic [XLEN-1:0]  wbData;
  logic             wbWe;
  logic [XLEN-1:0]  rawRs1;
  logic [XLEN-1:0]  rawRs2;
  logic [CNT_W-1:0] retiredCnt;
  Debug_t           debugReg;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves wbData
    // unassigned, which would infer a latch.
    wbData = '0;
    case (wb.MemtoReg_in_WB)
      WB_SRC_ALU: wbData = wb.ALU_in_WB;
      WB_SRC_MEM: wbData = wb.DMem_data_WB;
      WB_SRC_PC4: wbData = wb.PC4_in_WB;
      default:    wbData = '0;
    endcase
  end

  // A stalled, bubbled, reset or x0-targeted instruction neither writes nor bypasses.
  assign wbWe = wb.RegWrite_in_WB & wb.valid_in_WB & wb.en_WB &
                (wb.Rd_addr_WB != '0) & ~rst_WB;

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk_WB  (clk_WB),
    .rst_WB  (rst_WB),
    .wrEn    (wbWe),
    .wrAddr  (wb.Rd_addr_WB),
    .wrData  (wbData),
    .rdAddr1 (wb.Rs1_addr_WB),
    .rdAddr2 (wb.Rs2_addr_WB),
    .rdData1 (rawRs1),
    .rdData2 (rawRs2)
  );

  assign wb.Rs1_data_WB = (wb.Rs1_addr_WB == '0) ? '0 :
                          (wbWe && (wb.Rs1_addr_WB == wb.Rd_addr_WB)) ? wbData : rawRs1;
  assign wb.Rs2_data_WB = (wb.Rs2_addr_WB == '0) ? '0 :
                          (wbWe && (wb.Rs2_addr_WB == wb.Rd_addr_WB)) ? wbData : rawRs2;

  // Retirement counts every real instruction, including stores and branches.
  always_ff @(posedge clk_WB or posedge rst_WB) begin
    if (rst_WB) begin
      retiredCnt <= '0;
      debugReg   <= '0;
    end else if (wb.en_WB) begin
      debugReg <= wb.debug_in_WB;
      if (wb.valid_in_WB) begin
        retiredCnt <= retiredCnt + 1'b1;
        log_msg(STAGE_WB, EV_COMMIT, wb.debug_in_WB);
      end
    end
  end

  assign wb.wb_data_out_WB = wbData;
  assign wb.wb_we_out_WB   = wbWe;
  assign wb.retired_out_WB = retiredCnt;
  assign wb.debug_out_WB   = debugReg;

endmodule

// File: tb/tb_wb_regfile_stall.sv
// Bench for wb_regfile_stall: register-array reference model updated on each edge,
// compared against the DUT every mid-cycle, plus directed literal checks.
module tb_wb_regfile_stall;
  import wb_regfile_stall_pkg::*;

  logic clk_WB = 1'b0;
  logic rst_WB;
  logic chkOn  = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  always #5 clk_WB = ~clk_WB;

  wb_regfile_stall_if #(.XLEN(32), .CNT_W(32)) if0 ();
  wb_regfile_stall_if #(.XLEN(32), .CNT_W(3))  if1 ();

  wb_regfile_stall #(.CNT_W(32)) dut0 (.clk_WB(clk_WB), .rst_WB(rst_WB), .wb(if0));
  // Narrow-counter copy on identical stimulus so the counter wrap is reachable.
  wb_regfile_stall #(.CNT_W(3))  dut1 (.clk_WB(clk_WB), .rst_WB(rst_WB), .wb(if1));

  assign if1.en_WB          = if0.en_WB;
  assign if1.valid_in_WB    = if0.valid_in_WB;
  assign if1.debug_in_WB    = if0.debug_in_WB;
  assign if1.PC4_in_WB      = if0.PC4_in_WB;
  assign if1.Rd_addr_WB     = if0.Rd_addr_WB;
  assign if1.ALU_in_WB      = if0.ALU_in_WB;
  assign if1.DMem_data_WB   = if0.DMem_data_WB;
  assign if1.MemtoReg_in_WB = if0.MemtoReg_in_WB;
  assign if1.RegWrite_in_WB = if0.RegWrite_in_WB;
  assign if1.Rs1_addr_WB    = if0.Rs1_addr_WB;
  assign if1.Rs2_addr_WB    = if0.Rs2_addr_WB;

  // Reference model state
  logic [31:0] mregs [32];
  logic [31:0] mcnt = '0;
  Debug_t      mdbg = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expSel();
    case (if0.MemtoReg_in_WB)
      2'b00:   return if0.ALU_in_WB;
      2'b01:   return if0.DMem_data_WB;
      2'b10:   return if0.PC4_in_WB;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic expWe();
    return if0.RegWrite_in_WB && if0.valid_in_WB && if0.en_WB &&
           (if0.Rd_addr_WB != 5'd0) && !rst_WB;
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (expWe() && a == if0.Rd_addr_WB) return expSel();
    return mregs[a];
  endfunction

  always @(posedge clk_WB or posedge rst_WB) begin
    if (rst_WB) begin
      for (int i = 0; i < 32; i++) mregs[i] <= '0;
      mcnt <= '0;
      mdbg <= '0;
    end else begin
      if (expWe()) mregs[if0.Rd_addr_WB] <= expSel();
      if (if0.en_WB && if0.valid_in_WB) mcnt <= mcnt + 1;
      if (if0.en_WB) mdbg <= if0.debug_in_WB;
    end
  end

  always @(negedge clk_WB) begin
    if (chkOn) begin
      check("wb_data", if0.wb_data_out_WB, expSel());
      check("wb_we", if0.wb_we_out_WB, expWe());
      check("rs1_data", if0.Rs1_data_WB, expRead(if0.Rs1_addr_WB));
      check("rs2_data", if0.Rs2_data_WB, expRead(if0.Rs2_addr_WB));
      check("retired", if0.retired_out_WB, mcnt);
      check("debug_out", if0.debug_out_WB, mdbg);
      check("retired_narrow", if1.retired_out_WB, mcnt[2:0]);
      check("rs1_narrow", if1.Rs1_data_WB, expRead(if0.Rs1_addr_WB));
    end
  end

  task automatic step();
    @(posedge clk_WB);
    #1;
  endtask

  task automatic drive(input logic en, input logic valid, input logic rw,
                       input logic [4:0] rd, input logic [1:0] mtr,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc4, input logic [4:0] r1, input logic [4:0] r2);
    if0.en_WB          = en;
    if0.valid_in_WB    = valid;
    if0.RegWrite_in_WB = rw;
    if0.Rd_addr_WB     = rd;
    if0.MemtoReg_in_WB = mtr;
    if0.ALU_in_WB      = alu;
    if0.DMem_data_WB   = mem;
    if0.PC4_in_WB      = pc4;
    if0.Rs1_addr_WB    = r1;
    if0.Rs2_addr_WB    = r2;
    if0.debug_in_WB    = {$urandom, $urandom};
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, r1, r2);
  endtask

  initial begin
    rst_WB = 1'b1;
    idle(5'd0, 5'd0);
    @(posedge clk_WB);
    #1 chkOn = 1'b1;
    step();
    rst_WB = 1'b0;
    #1;
    check("reset_retired", if0.retired_out_WB, 32'h0);
    check("reset_debug", if0.debug_out_WB, 64'h0);

    // All registers read zero after reset
    for (int i = 1; i < 32; i += 2) begin
      idle(5'(i), 5'(i + 1));
      #1;
      check("reset_rs1", if0.Rs1_data_WB, 32'h0);
      check("reset_rs2", if0.Rs2_data_WB, 32'h0);
      step();
    end

    // Reset held across the edge drops the pending x5 write
    drive(1'b1, 1'b1, 1'b1, 5'd5, 2'b00, 32'h55, 32'h0, 32'h0, 5'd5, 5'd0);
    #2 rst_WB = 1'b1;
    step();
    rst_WB = 1'b0;
    idle(5'd5, 5'd0);
    #1;
    check("x5_after_rst", if0.Rs1_data_WB, 32'h0);
    check("cnt_after_rst", if0.retired_out_WB, 32'h0);

    // Load into x3 with same-cycle bypass
    step();
    drive(1'b1, 1'b1, 1'b1, 5'd3, 2'b01, 32'h1111, 32'hDEADBEEF, 32'h2222, 5'd3, 5'd3);
    #1;
    check("bypass_rs1", if0.Rs1_data_WB, 32'hDEADBEEF);
    check("bypass_rs2", if0.Rs2_data_WB, 32'hDEADBEEF);
    check("bypass_we", if0.wb_we_out_WB, 1'b1);
    step();
    idle(5'd3, 5'd0);
    #1;
    check("x3_committed", if0.Rs1_data_WB, 32'hDEADBEEF);

    // Write to x0 is ignored
    step();
    drive(1'b1, 1'b1, 1'b1, 5'd0, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd0, 5'd0);
    #1;
    check("x0_rs1", if0.Rs1_data_WB, 32'h0);
    check("x0_rs2", if0.Rs2_data_WB, 32'h0);
    check("x0_we", if0.wb_we_out_WB, 1'b0);
    check("x0_wbdata", if0.wb_data_out_WB, 32'h1234);
    step();
    idle(5'd0, 5'd0);
    #1;
    check("x0_after", if0.Rs1_data_WB, 32'h0);
    check("cnt_two", if0.retired_out_WB, 32'h2);

    // Stall with a pending PC4 write to x7, then release
    step();
    drive(1'b0, 1'b1, 1'b1, 5'd7, 2'b10, 32'h0, 32'h0, 32'h104, 5'd7, 5'd0);
    #1;
    check("stall_no_bypass", if0.Rs1_data_WB, 32'h0);
    check("stall_we", if0.wb_we_out_WB, 1'b0);
    step();
    check("stall_x7", if0.Rs1_data_WB, 32'h0);
    check("stall_cnt", if0.retired_out_WB, 32'h2);
    if0.en_WB = 1'b1;
    #1;
    check("unstall_bypass", if0.Rs1_data_WB, 32'h104);
    step();
    idle(5'd7, 5'd0);
    #1;
    check("unstall_x7", if0.Rs1_data_WB, 32'h104);
    check("unstall_cnt", if0.retired_out_WB, 32'h3);

    // Retirement: 2 writes, 1 store, 1 bubble
    step();
    rst_WB = 1'b1;
    #1 rst_WB = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 5'd9,  2'b00, 32'h9, 32'h0, 32'h0, 5'd9, 5'd10);
    step();
    drive(1'b1, 1'b1, 1'b1, 5'd10, 2'b01, 32'h0, 32'hA, 32'h0, 5'd9, 5'd10);
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd11, 2'b00, 32'hB, 32'h0, 32'h0, 5'd11, 5'd10);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd12, 2'b00, 32'hC, 32'h0, 32'h0, 5'd12, 5'd9);
    step();
    idle(5'd12, 5'd10);
    #1;
    check("retire_three", if0.retired_out_WB, 32'h3);
    check("retire_three_narrow", if1.retired_out_WB, 3'd3);
    check("bubble_no_write", if0.Rs1_data_WB, 32'h0);
    check("x10_mem", if0.Rs2_data_WB, 32'hA);

    // Narrow counter wraps from all-ones to zero
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      step();
    end
    idle(5'd0, 5'd0);
    #1;
    check("retire_eight", if0.retired_out_WB, 32'h8);
    check("wrap_narrow", if1.retired_out_WB, 3'd0);

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 800; n++) begin
      logic [4:0] rd;
      step();
      rd = 5'($urandom);
      drive(($urandom % 8) != 0, ($urandom % 5) != 0, ($urandom % 4) != 0, rd,
            2'($urandom), $urandom, $urandom, $urandom,
            (($urandom % 3) == 0) ? rd : 5'($urandom),
            (($urandom % 3) == 0) ? rd : 5'($urandom));
      if (($urandom % 60) == 0) begin
        #2 rst_WB = 1'b1;
        #1 rst_WB = 1'b0;
      end
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
